// File: rtl/particle_issue_ctrl_if.sv
// rtl/particle_issue_ctrl_if.sv - issue controller memory/pipeline bundle
// master = issue controller, slave = memories and compute pipeline side.
interface particle_issue_ctrl_if #(
  parameter int AW = 4
);
  localparam int PW = 114;
  localparam int NW = 14 * PW;

  logic          start;
  logic          ref_rd_en;
  logic [AW-1:0] ref_rd_addr;
  logic [PW-1:0] ref_rd_data;
  logic          nbr_rd_en;
  logic [AW-1:0] nbr_rd_addr;
  logic [NW-1:0] nbr_rd_data;
  logic [PW-1:0] reference;
  logic [NW-1:0] neighbors;
  logic          slot_valid;
  logic          read_controller_done;
  logic          pipeline_done;
  logic          busy;
  logic          done;

  modport master (
    input  start, ref_rd_data, nbr_rd_data, pipeline_done,
    output ref_rd_en, ref_rd_addr, nbr_rd_en, nbr_rd_addr,
           reference, neighbors, slot_valid, read_controller_done, busy, done
  );

  modport slave (
    output start, ref_rd_data, nbr_rd_data, pipeline_done,
    input  ref_rd_en, ref_rd_addr, nbr_rd_en, nbr_rd_addr,
           reference, neighbors, slot_valid, read_controller_done, busy, done
  );
endinterface

// File: rtl/particle_issue_ctrl.sv
// rtl/particle_issue_ctrl.sv - walks neighbour rows x reference particles, issuing held slots
// One slot = one reference particle + 14 neighbour particles, held SLOT_CYCLES cycles.
module particle_issue_ctrl #(
  parameter int REF_DEPTH   = 16,
  parameter int NBR_DEPTH   = 16,
  parameter int AW          = 4,
  parameter int SLOT_CYCLES = 16
) (
  input  logic                  fast_clk,
  input  logic                  reset,
  particle_issue_ctrl_if.master bus
);
  localparam int PW       = 114;
  localparam int NN       = 14;
  localparam int NULL_BIT = 96;
  localparam int CW       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  localparam logic [AW:0]   REF_END   = (AW+1)'(REF_DEPTH);
  localparam logic [AW:0]   NBR_END   = (AW+1)'(NBR_DEPTH);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_N,
    S_WAIT_N,
    S_FETCH_R,
    S_WAIT_R,
    S_ISSUE,
    S_NEXT_ROW,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q;
  // One extra bit so a full-depth index reaches REF_END/NBR_END instead of wrapping.
  logic [AW:0]      i_q, j_q;
  logic [AW:0]      i_d, j_d;
  logic [CW-1:0]    cnt_q;

  logic             ref_rd_en_q;
  logic [AW-1:0]    ref_rd_addr_q;
  logic             nbr_rd_en_q;
  logic [AW-1:0]    nbr_rd_addr_q;
  logic [PW-1:0]    reference_q;
  logic [NN*PW-1:0] neighbors_q;
  logic             slot_valid_q;
  logic             rc_done_q;
  logic             busy_q;
  logic             done_q;

  logic             nbr_all_null;

  assign i_d = i_q + (AW+1)'(1);
  assign j_d = j_q + (AW+1)'(1);

  always_comb begin
    nbr_all_null = 1'b1;
    for (int k = 0; k < NN; k++) begin
      nbr_all_null = nbr_all_null & bus.nbr_rd_data[k*PW + NULL_BIT];
    end
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      cnt_q         <= '0;
      ref_rd_en_q   <= 1'b0;
      ref_rd_addr_q <= '0;
      nbr_rd_en_q   <= 1'b0;
      nbr_rd_addr_q <= '0;
      reference_q   <= '0;
      neighbors_q   <= '0;
      slot_valid_q  <= 1'b0;
      rc_done_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q       <= S_FETCH_N;
            i_q           <= '0;
            j_q           <= '0;
            done_q        <= 1'b0;
            rc_done_q     <= 1'b0;
            busy_q        <= 1'b1;
            nbr_rd_en_q   <= 1'b1;
            nbr_rd_addr_q <= '0;
          end
        end

        S_FETCH_N: begin
          nbr_rd_en_q <= 1'b0;
          state_q     <= S_WAIT_N;
        end

        S_WAIT_N: begin
          if (j_q == NBR_END || nbr_all_null) begin
            rc_done_q <= 1'b1;
            state_q   <= S_DRAIN;
          end else begin
            neighbors_q   <= bus.nbr_rd_data;
            i_q           <= '0;
            ref_rd_en_q   <= 1'b1;
            ref_rd_addr_q <= '0;
            state_q       <= S_FETCH_R;
          end
        end

        S_FETCH_R: begin
          ref_rd_en_q <= 1'b0;
          state_q     <= S_WAIT_R;
        end

        // A null reference slot ends the row: particles are packed from index 0.
        S_WAIT_R: begin
          if (bus.ref_rd_data[NULL_BIT]) begin
            state_q <= S_NEXT_ROW;
          end else begin
            reference_q  <= bus.ref_rd_data;
            slot_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_q        <= '0;
            i_q          <= i_d;
            slot_valid_q <= 1'b0;
            if (i_d == REF_END) begin
              state_q <= S_NEXT_ROW;
            end else begin
              ref_rd_en_q   <= 1'b1;
              ref_rd_addr_q <= i_d[AW-1:0];
              state_q       <= S_FETCH_R;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_NEXT_ROW: begin
          j_q <= j_d;
          if (j_d == NBR_END) begin
            rc_done_q <= 1'b1;
            state_q   <= S_DRAIN;
          end else begin
            nbr_rd_en_q   <= 1'b1;
            nbr_rd_addr_q <= j_d[AW-1:0];
            state_q       <= S_FETCH_N;
          end
        end

        S_DRAIN: begin
          if (bus.pipeline_done) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ref_rd_en            = ref_rd_en_q;
  assign bus.ref_rd_addr          = ref_rd_addr_q;
  assign bus.nbr_rd_en            = nbr_rd_en_q;
  assign bus.nbr_rd_addr          = nbr_rd_addr_q;
  assign bus.reference            = reference_q;
  assign bus.neighbors            = neighbors_q;
  assign bus.slot_valid           = slot_valid_q;
  assign bus.read_controller_done = rc_done_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
endmodule

// File: tb/tb_particle_issue_ctrl.sv
// tb/tb_particle_issue_ctrl.sv - directed/randomized bench for particle_issue_ctrl
// Expected slot order, data and cycle timing come from a row/particle walk of the memory contents.
module tb_particle_issue_ctrl;
  localparam int RD = 4;
  localparam int ND = 2;
  localparam int AWB = 2;
  localparam int SC = 16;
  localparam int PW = 114;
  localparam int NN = 14;

  logic fast_clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  particle_issue_ctrl_if #(.AW(AWB)) bus ();

  particle_issue_ctrl #(
    .REF_DEPTH(RD), .NBR_DEPTH(ND), .AW(AWB), .SLOT_CYCLES(SC)
  ) dut (
    .fast_clk(fast_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 fast_clk = ~fast_clk;
  always @(posedge fast_clk) cyc <= cyc + 1;

  logic [PW-1:0] ref_mem [RD];
  logic [PW-1:0] nbr_mem [ND][NN];

  function automatic logic [PW-1:0] rand_word(input bit nul);
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    t[96] = nul;
    return t[PW-1:0];
  endfunction

  function automatic logic [NN*PW-1:0] pack_row(input int j);
    logic [NN*PW-1:0] r;
    for (int k = 0; k < NN; k++) r[k*PW +: PW] = nbr_mem[j][k];
    return r;
  endfunction

  function automatic logic [NN*PW-1:0] junk_row();
    logic [NN*PW-1:0] r;
    for (int k = 0; k < NN; k++) r[k*PW +: PW] = rand_word($urandom_range(0, 1) == 1);
    return r;
  endfunction

  function automatic bit row_all_null(input int j);
    bit a;
    a = 1'b1;
    for (int k = 0; k < NN; k++) a = a & nbr_mem[j][k][96];
    return a;
  endfunction

  // Memories: data only valid the cycle after a strobe, junk otherwise.
  always @(posedge fast_clk) begin
    bus.ref_rd_data <= bus.ref_rd_en ? ref_mem[bus.ref_rd_addr] : rand_word($urandom_range(0, 1) == 1);
    bus.nbr_rd_data <= bus.nbr_rd_en ? pack_row(int'(bus.nbr_rd_addr)) : junk_row();
  end

  logic [PW-1:0]    obs_ref_q [$];
  logic [NN*PW-1:0] obs_nbr_q [$];
  int               obs_start_q [$];
  int               obs_len_q [$];
  int               rd_addr_q [$];
  int               unstable = 0;
  int               cur_len = 0;
  logic             sv_prev = 1'b0;

  always @(negedge fast_clk) begin
    if (bus.ref_rd_en === 1'b1) rd_addr_q.push_back(int'(bus.ref_rd_addr));
    if (bus.slot_valid === 1'b1) begin
      if (!sv_prev) begin
        obs_ref_q.push_back(bus.reference);
        obs_nbr_q.push_back(bus.neighbors);
        obs_start_q.push_back(cyc);
        cur_len <= 1;
      end else begin
        cur_len <= cur_len + 1;
        if (bus.reference !== obs_ref_q[$] || bus.neighbors !== obs_nbr_q[$]) unstable <= unstable + 1;
      end
    end else if (sv_prev) begin
      obs_len_q.push_back(cur_len);
    end
    sv_prev <= (bus.slot_valid === 1'b1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_pass(input string tag, input bit disturb);
    int exp_i[$], exp_j[$], exp_rd[$], exp_st[$];
    int t, n, b_s, b_l, b_rd, u0, c0, guard, ns;
    bit brk, stop;
    t = 0;
    stop = 0;
    for (int j = 0; j < ND; j++) begin
      if (!stop) begin
        if (row_all_null(j)) begin
          t += 2;
          stop = 1;
        end else begin
          n = 0;
          brk = 0;
          for (int i = 0; i < RD; i++) begin
            if (!brk) begin
              exp_rd.push_back(i);
              if (ref_mem[i][96]) brk = 1;
              else begin
                exp_i.push_back(i);
                exp_j.push_back(j);
                exp_st.push_back(t + 4 + (SC + 2) * n);
                n++;
              end
            end
          end
          t += (SC + 2) * n + 3 + (brk ? 2 : 0);
        end
      end
    end

    b_s = obs_start_q.size();
    b_l = obs_len_q.size();
    b_rd = rd_addr_q.size();
    u0 = unstable;

    bus.start = 1'b1;
    @(posedge fast_clk); #1;
    bus.start = 1'b0;
    c0 = cyc;
    check({tag, "_busy_start"}, int'(bus.busy), 1);

    if (disturb) begin
      guard = 0;
      while (bus.slot_valid !== 1'b1 && guard < 100) begin
        @(posedge fast_clk); #1;
        guard++;
      end
      bus.start = 1'b1;
      bus.pipeline_done = 1'b1;
      @(posedge fast_clk); #1;
      bus.start = 1'b0;
      bus.pipeline_done = 1'b0;
      check({tag, "_disturb_done"}, int'(bus.done), 0);
      check({tag, "_disturb_slot"}, int'(bus.slot_valid), 1);
    end

    guard = 0;
    while (bus.read_controller_done !== 1'b1 && guard < 5000) begin
      @(posedge fast_clk); #1;
      guard++;
    end
    check({tag, "_rcd"}, int'(bus.read_controller_done), 1);
    check({tag, "_rcd_cycle"}, cyc - c0, t);

    ns = obs_start_q.size() - b_s;
    check({tag, "_slots"}, ns, exp_i.size());
    for (int k = 0; k < ns && k < exp_i.size(); k++) begin
      check($sformatf("%s_ref_j%0d_i%0d", tag, exp_j[k], exp_i[k]),
            int'(obs_ref_q[b_s+k] === ref_mem[exp_i[k]]), 1);
      check($sformatf("%s_nbr_j%0d_i%0d", tag, exp_j[k], exp_i[k]),
            int'(obs_nbr_q[b_s+k] === pack_row(exp_j[k])), 1);
      check($sformatf("%s_start_%0d", tag, k), obs_start_q[b_s+k] - c0, exp_st[k]);
      if (b_l + k < obs_len_q.size()) check($sformatf("%s_len_%0d", tag, k), obs_len_q[b_l+k], SC);
    end
    check({tag, "_stable"}, unstable - u0, 0);
    check({tag, "_rd_count"}, rd_addr_q.size() - b_rd, exp_rd.size());
    for (int k = 0; k < exp_rd.size() && b_rd + k < rd_addr_q.size(); k++)
      check($sformatf("%s_rd_addr_%0d", tag, k), rd_addr_q[b_rd+k], exp_rd[k]);

    repeat (10) @(posedge fast_clk);
    #1;
    check({tag, "_drain_done"}, int'(bus.done), 0);
    check({tag, "_drain_busy"}, int'(bus.busy), 1);
    bus.pipeline_done = 1'b1;
    @(posedge fast_clk); #1;
    bus.pipeline_done = 1'b0;
    check({tag, "_done"}, int'(bus.done), 1);
    check({tag, "_done_busy"}, int'(bus.busy), 0);
    check({tag, "_done_rcd"}, int'(bus.read_controller_done), 1);
    repeat (2) @(posedge fast_clk);
    #1;
    check({tag, "_done_hold"}, int'(bus.done), 1);
    check({tag, "_ref_hold"}, int'(bus.reference === obs_ref_q[$]), 1);
  endtask

  initial begin
    int guard, b_s;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.pipeline_done = 1'b0;
    for (int i = 0; i < RD; i++) ref_mem[i] = rand_word(1'b0);
    for (int j = 0; j < ND; j++)
      for (int k = 0; k < NN; k++) nbr_mem[j][k] = rand_word(1'b0);

    repeat (3) @(posedge fast_clk);
    #1;
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (5) @(posedge fast_clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_slot_valid", int'(bus.slot_valid), 0);
    check("rst_rcd", int'(bus.read_controller_done), 0);
    check("rst_ref_rd_en", int'(bus.ref_rd_en), 0);
    check("rst_nbr_rd_en", int'(bus.nbr_rd_en), 0);
    check("rst_addrs", int'(bus.ref_rd_addr) + int'(bus.nbr_rd_addr), 0);
    check("rst_reference", int'(bus.reference === '0), 1);
    check("rst_neighbors", int'(bus.neighbors === '0), 1);

    do_pass("full", 1'b0);

    // Abort in the middle of the third slot, then replay from the start.
    b_s = obs_start_q.size();
    bus.start = 1'b1;
    @(posedge fast_clk); #1;
    bus.start = 1'b0;
    guard = 0;
    while (obs_start_q.size() < b_s + 3 && guard < 200) begin
      @(posedge fast_clk); #1;
      guard++;
    end
    check("abort_reached_slot3", obs_start_q.size() - b_s, 3);
    repeat (5) @(posedge fast_clk);
    #1;
    reset = 1'b1;
    @(posedge fast_clk); #1;
    check("abort_slot_valid", int'(bus.slot_valid), 0);
    check("abort_reference", int'(bus.reference === '0), 1);
    check("abort_neighbors", int'(bus.neighbors === '0), 1);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_rcd", int'(bus.read_controller_done), 0);
    reset = 1'b0;
    @(posedge fast_clk); #1;
    do_pass("replay", 1'b0);

    do_pass("disturb", 1'b1);

    ref_mem[2] = rand_word(1'b1);
    do_pass("refnull", 1'b0);

    ref_mem[2] = rand_word(1'b0);
    for (int k = 0; k < NN; k++) nbr_mem[1][k] = rand_word(1'b1);
    do_pass("rownull", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
